assoc_data_cache: RTL and testbench

Parametrised, trace-driven, set-associative L1 data cache model with true-LRU replacement and write-back/write-allocate policy. Sits between the trace-file command source and a next-level memory stub. Commands are accepted with a valid/ready handshake, and line fills and writebacks use a req/ack handshake. Reports per-access hit/miss pulses and keeps running statistics counters. Tags and state only: line payload is not stored.

---
 rtl/cache_pkg.sv | 29 ++
 rtl/lru_tracker.sv | 51 +++++
 rtl/assoc_data_cache.sv | 239 +++++++++++++++++++++++
 tb/tb_assoc_data_cache.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared command codes, FSM states and width helpers for assoc_data_cache
package cache_pkg;

   localparam logic [3:0] CMD_READ  = 4'd0;
   localparam logic [3:0] CMD_WRITE = 4'd1;
   localparam logic [3:0] CMD_INVAL = 4'd3;
   localparam logic [3:0] CMD_CLEAR = 4'd8;

   typedef enum logic [2:0] {
      CLEAR,
      IDLE,
      LOOKUP,
      WB,
      FILL
   } state_t;

   function automatic int off_w(input int line_bytes);
      return $clog2(line_bytes);
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int addr_w, input int line_bytes, input int sets);
      return addr_w - $clog2(sets) - $clog2(line_bytes);
   endfunction

endpackage

// File: rtl/lru_tracker.sv
// rtl/lru_tracker.sv - true-LRU age update and victim selection for one set
module lru_tracker #(
   parameter int WAYS  = 8,
   parameter int WAY_W = $clog2(WAYS)
) (
   input  logic [WAYS*WAY_W-1:0] ages,
   input  logic [WAYS-1:0]       valid,
   input  logic [WAY_W-1:0]      way,
   output logic [WAYS*WAY_W-1:0] ages_next,
   output logic [WAY_W-1:0]      victim
);

   logic [WAY_W-1:0] old_age;
   logic [WAY_W-1:0] age_i;
   logic             found;

   // Accessed way becomes youngest; only ways younger than it age by one,
   // so the ages remain a permutation of 0..WAYS-1.
   always_comb begin
      old_age   = ages[way*WAY_W +: WAY_W];
      age_i     = '0;
      ages_next = ages;
      for (int i = 0; i < WAYS; i++) begin
         age_i = ages[i*WAY_W +: WAY_W];
         if (WAY_W'(i) == way) begin
            ages_next[i*WAY_W +: WAY_W] = '0;
         end else if (age_i < old_age) begin
            ages_next[i*WAY_W +: WAY_W] = age_i + WAY_W'(1);
         end
      end
   end

   always_comb begin
      victim = '0;
      found  = 1'b0;
      for (int i = 0; i < WAYS; i++) begin
         if (!found && !valid[i]) begin
            victim = WAY_W'(i);
            found  = 1'b1;
         end
      end
      if (!found) begin
         for (int i = 0; i < WAYS; i++) begin
            if (ages[i*WAY_W +: WAY_W] == WAY_W'(WAYS - 1)) begin
               victim = WAY_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/assoc_data_cache.sv
// rtl/assoc_data_cache.sv - set-associative write-back/write-allocate L1 data cache tag model
module assoc_data_cache
   import cache_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int LINE_BYTES = 64,
   parameter int SETS       = 256,
   parameter int WAYS       = 8,
   parameter int CNT_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        n,
   input  logic [ADDR_W-1:0] add_in,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] add_out,
   input  logic              mem_ack,
   output logic              hit,
   output logic              miss,
   output logic [CNT_W-1:0]  read_cnt,
   output logic [CNT_W-1:0]  write_cnt,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int OFF_W  = off_w(LINE_BYTES);
   localparam int IDX_W  = idx_w(SETS);
   localparam int TAG_W  = tag_w(ADDR_W, LINE_BYTES, SETS);
   localparam int WAY_W  = $clog2(WAYS);
   localparam int LINE_W = ADDR_W - OFF_W;

   state_t state, state_nx;

   logic [3:0]        cmd_q;
   logic [LINE_W-1:0] line_q;
   logic [IDX_W-1:0]  clr_idx;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [TAG_W-1:0]  wb_tag_q;
   logic [WAY_W-1:0]  way_q;
   logic [WAY_W-1:0]  hit_way;
   logic [WAY_W-1:0]  victim;
   logic [WAY_W-1:0]  lru_way;
   logic              hit_q;
   logic              miss_q;
   logic              lk_hit;
   logic              is_rw;
   logic              is_inv;
   logic              unused_off;

   logic [WAYS-1:0]              valid_arr [SETS];
   logic [WAYS-1:0]              dirty_arr [SETS];
   logic [WAYS-1:0][TAG_W-1:0]   tag_arr   [SETS];
   logic [WAYS*WAY_W-1:0]        age_arr   [SETS];

   logic [WAYS-1:0]              set_valid;
   logic [WAYS-1:0]              set_dirty;
   logic [WAYS-1:0][TAG_W-1:0]   set_tags;
   logic [WAYS*WAY_W-1:0]        set_ages;
   logic [WAYS*WAY_W-1:0]        ages_next;
   logic [WAYS*WAY_W-1:0]        age_init;

   assign unused_off = ^add_in[OFF_W-1:0];

   assign idx    = line_q[IDX_W-1:0];
   assign tag    = line_q[LINE_W-1:IDX_W];
   assign is_rw  = (cmd_q == CMD_READ) || (cmd_q == CMD_WRITE);
   assign is_inv = (cmd_q == CMD_INVAL);

   assign set_valid = valid_arr[idx];
   assign set_dirty = dirty_arr[idx];
   assign set_tags  = tag_arr[idx];
   assign set_ages  = age_arr[idx];

   always_comb begin
      lk_hit  = 1'b0;
      hit_way = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (set_valid[i] && (set_tags[i] == tag)) begin
            lk_hit  = 1'b1;
            hit_way = WAY_W'(i);
         end
      end
   end

   always_comb begin
      age_init = '0;
      for (int i = 0; i < WAYS; i++) begin
         age_init[i*WAY_W +: WAY_W] = WAY_W'(i);
      end
   end

   // The fill installs into the way chosen at lookup; a hit refreshes the hit way.
   assign lru_way = (state == FILL) ? way_q : hit_way;

   lru_tracker #(
      .WAYS  (WAYS),
      .WAY_W (WAY_W)
   ) u_lru (
      .ages      (set_ages),
      .valid     (set_valid),
      .way       (lru_way),
      .ages_next (ages_next),
      .victim    (victim)
   );

   always_comb begin
      state_nx = state;
      case (state)
         CLEAR: begin
            if (clr_idx == IDX_W'(SETS - 1)) state_nx = IDLE;
         end
         IDLE: begin
            if (cmd_valid) state_nx = (n == CMD_CLEAR) ? CLEAR : LOOKUP;
         end
         LOOKUP: begin
            if (is_rw) begin
               if (lk_hit)                                      state_nx = IDLE;
               else if (set_valid[victim] && set_dirty[victim]) state_nx = WB;
               else                                             state_nx = FILL;
            end else if (is_inv && lk_hit && set_dirty[hit_way]) begin
               state_nx = WB;
            end else begin
               state_nx = IDLE;
            end
         end
         WB: begin
            if (mem_ack) state_nx = is_inv ? IDLE : FILL;
         end
         FILL: begin
            if (mem_ack) state_nx = IDLE;
         end
         default: state_nx = CLEAR;
      endcase
   end

   // Decoded straight from state so an asynchronous reset drops mem_req at once.
   always_comb begin
      cmd_ready = (state == IDLE);
      mem_req   = (state == WB) || (state == FILL);
      mem_we    = (state == WB);
      add_out   = '0;
      if (state == WB)        add_out = {wb_tag_q, idx, {OFF_W{1'b0}}};
      else if (state == FILL) add_out = {tag, idx, {OFF_W{1'b0}}};
   end

   assign hit  = hit_q;
   assign miss = miss_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= CLEAR;
         clr_idx   <= '0;
         cmd_q     <= '0;
         line_q    <= '0;
         way_q     <= '0;
         wb_tag_q  <= '0;
         hit_q     <= 1'b0;
         miss_q    <= 1'b0;
         read_cnt  <= '0;
         write_cnt <= '0;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
      end else begin
         state  <= state_nx;
         hit_q  <= 1'b0;
         miss_q <= 1'b0;
         if (state == CLEAR) clr_idx <= clr_idx + IDX_W'(1);
         if (state == IDLE && cmd_valid) begin
            cmd_q  <= n;
            line_q <= add_in[ADDR_W-1:OFF_W];
            if (n == CMD_CLEAR) begin
               read_cnt  <= '0;
               write_cnt <= '0;
               hit_cnt   <= '0;
               miss_cnt  <= '0;
            end
         end
         if (state == LOOKUP) begin
            if (is_rw) begin
               if (cmd_q == CMD_READ) read_cnt  <= read_cnt + CNT_W'(1);
               else                   write_cnt <= write_cnt + CNT_W'(1);
               if (lk_hit) begin
                  hit_q   <= 1'b1;
                  hit_cnt <= hit_cnt + CNT_W'(1);
               end else begin
                  miss_q   <= 1'b1;
                  miss_cnt <= miss_cnt + CNT_W'(1);
                  way_q    <= victim;
                  wb_tag_q <= set_tags[victim];
               end
            end else if (is_inv && lk_hit) begin
               way_q    <= hit_way;
               wb_tag_q <= tag;
            end
         end
      end
   end

   // Line state is initialised by the CLEAR sweep rather than by reset.
   always_ff @(posedge clk) begin
      case (state)
         CLEAR: begin
            valid_arr[clr_idx] <= '0;
            dirty_arr[clr_idx] <= '0;
            age_arr[clr_idx]   <= age_init;
         end
         LOOKUP: begin
            if (lk_hit) begin
               if (is_rw) begin
                  age_arr[idx] <= ages_next;
                  if (cmd_q == CMD_WRITE) dirty_arr[idx][hit_way] <= 1'b1;
               end else if (is_inv && !set_dirty[hit_way]) begin
                  valid_arr[idx][hit_way] <= 1'b0;
               end
            end
         end
         WB: begin
            if (mem_ack && is_inv) begin
               valid_arr[idx][way_q] <= 1'b0;
               dirty_arr[idx][way_q] <= 1'b0;
            end
         end
         FILL: begin
            if (mem_ack) begin
               tag_arr[idx][way_q]   <= tag;
               valid_arr[idx][way_q] <= 1'b1;
               dirty_arr[idx][way_q] <= (cmd_q == CMD_WRITE);
               age_arr[idx]          <= ages_next;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_assoc_data_cache.sv
// tb/tb_assoc_data_cache.sv - scoreboard bench for assoc_data_cache with directed trace vectors
module tb_assoc_data_cache;

   localparam int K_NONE = 0;
   localparam int K_HIT  = 1;
   localparam int K_MISS = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  n;
   logic [31:0] add_in;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] add_out;
   logic        mem_ack;
   logic        hit;
   logic        miss;
   logic [31:0] read_cnt;
   logic [31:0] write_cnt;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic hold_ack = 1'b0;

   typedef struct {
      logic is_hit;
      int   due;
   } pulse_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
   } txn_t;

   pulse_t pulse_q[$];
   txn_t   txn_q[$];

   assoc_data_cache dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .n         (n),
      .add_in    (add_in),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .add_out   (add_out),
      .mem_ack   (mem_ack),
      .hit       (hit),
      .miss      (miss),
      .read_cnt  (read_cnt),
      .write_cnt (write_cnt),
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic exp_txn(input logic we, input logic [31:0] addr);
      txn_t t;
      t.we   = we;
      t.addr = addr;
      txn_q.push_back(t);
   endtask

   task automatic send(input logic [3:0] c, input logic [31:0] a, input int kind);
      int     t = 0;
      pulse_t p;
      @(negedge clk);
      while (!cmd_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("cmd_ready_before_send", cmd_ready, 1);
      if (kind != K_NONE) begin
         p.is_hit = (kind == K_HIT);
         p.due    = cyc + 2;
         pulse_q.push_back(p);
      end
      cmd_valid = 1'b1;
      n         = c;
      add_in    = a;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      add_in    = '0;
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while (!cmd_ready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      check("wait_idle", cmd_ready, 1);
   endtask

   task automatic check_cnt(input int r, input int w, input int h, input int m);
      check("read_cnt", read_cnt, r);
      check("write_cnt", write_cnt, w);
      check("hit_cnt", hit_cnt, h);
      check("miss_cnt", miss_cnt, m);
   endtask

   task automatic count_clear(input string name);
      int c = 0;
      while (!cmd_ready && c < 1000) begin
         c++;
         @(negedge clk);
      end
      check(name, c, 256);
   endtask

   // Pulse monitor
   initial begin : pulse_mon
      pulse_t p;
      forever begin
         @(negedge clk);
         if (hit || miss) begin
            check("hit_miss_exclusive", hit && miss, 0);
            if (pulse_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse: hit=%0d miss=%0d, expected none", hit, miss);
            end else begin
               p = pulse_q.pop_front();
               check("pulse_kind", hit, p.is_hit);
               check("pulse_cycle", cyc, p.due);
            end
         end
      end
   end

   // Memory stub and transaction monitor
   initial begin : mem_stub
      txn_t        e;
      logic [32:0] held;
      int          t;
      mem_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            if (txn_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_txn: we=%0d addr=%0h, expected none", mem_we, add_out);
            end else begin
               e = txn_q.pop_front();
               check("txn_we", mem_we, e.we);
               check("txn_addr", add_out, e.addr);
            end
            if (hold_ack) begin
               t = 0;
               while (mem_req && t < 1000) begin
                  @(negedge clk);
                  t++;
               end
               t = 0;
               while (rst && t < 1000) begin
                  @(negedge clk);
                  t++;
               end
               @(negedge clk);
               mem_ack = 1'b1;
               @(negedge clk);
               mem_ack = 1'b0;
            end else begin
               held = {mem_we, add_out};
               repeat (2) @(negedge clk);
               check("txn_held", {mem_req, mem_we, add_out}, {1'b1, held});
               mem_ack = 1'b1;
               @(negedge clk);
               mem_ack = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin : stim
      int t;
      cmd_valid = 1'b0;
      n         = '0;
      add_in    = '0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_hit", hit, 0);
      check("rst_miss", miss, 0);
      check("rst_add_out", add_out, 0);
      check_cnt(0, 0, 0, 0);
      rst = 1'b0;
      count_clear("clear_cycles_reset");

      exp_txn(1'b0, 32'h0000_1000);
      send(4'd0, 32'h0000_1000, K_MISS);
      wait_idle();
      send(4'd0, 32'h0000_103C, K_HIT);
      wait_idle();
      check_cnt(2, 0, 1, 1);

      for (int k = 0; k < 9; k++) begin
         exp_txn(1'b0, 32'(k) * 32'h4000);
         send(4'd0, 32'(k) * 32'h4000, K_MISS);
         wait_idle();
      end
      exp_txn(1'b0, 32'h0);
      send(4'd0, 32'h0, K_MISS);
      wait_idle();
      send(4'd0, 32'h8000, K_HIT);
      wait_idle();
      check_cnt(13, 0, 2, 11);

      exp_txn(1'b0, 32'h100);
      send(4'd1, 32'h100, K_MISS);
      wait_idle();
      for (int k = 0; k < 8; k++) begin
         if (k == 7) exp_txn(1'b1, 32'h100);
         exp_txn(1'b0, 32'h4100 + 32'(k) * 32'h4000);
         send(4'd0, 32'h4100 + 32'(k) * 32'h4000, K_MISS);
         wait_idle();
      end
      check_cnt(21, 1, 2, 20);

      send(4'd3, 32'h0000_1000, K_NONE);
      wait_idle();
      exp_txn(1'b0, 32'h0000_1000);
      send(4'd0, 32'h0000_1000, K_MISS);
      wait_idle();
      check_cnt(22, 1, 2, 21);
      send(4'd3, 32'h7000_0000, K_NONE);
      wait_idle();
      send(4'd5, 32'h0000_1000, K_NONE);
      wait_idle();
      check_cnt(22, 1, 2, 21);
      send(4'd0, 32'h0000_1000, K_HIT);
      wait_idle();

      exp_txn(1'b0, 32'h3000);
      send(4'd0, 32'h3000, K_MISS);
      wait_idle();
      send(4'd1, 32'h3010, K_HIT);
      wait_idle();
      exp_txn(1'b1, 32'h3000);
      send(4'd3, 32'h3000, K_NONE);
      wait_idle();
      exp_txn(1'b0, 32'h3000);
      send(4'd0, 32'h3000, K_MISS);
      wait_idle();
      check_cnt(25, 2, 4, 23);

      send(4'd8, 32'h0, K_NONE);
      check_cnt(0, 0, 0, 0);
      @(negedge clk);
      count_clear("clear_cycles_cmd");
      exp_txn(1'b0, 32'h0000_1000);
      send(4'd0, 32'h0000_1000, K_MISS);
      wait_idle();
      exp_txn(1'b0, 32'h3000);
      send(4'd0, 32'h3000, K_MISS);
      wait_idle();
      check_cnt(2, 0, 0, 2);

      hold_ack = 1'b1;
      exp_txn(1'b0, 32'h5000);
      send(4'd0, 32'h5000, K_MISS);
      t = 0;
      while (!mem_req && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("fill_started", mem_req, 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_drops_req", mem_req, 0);
      check("rst_drops_ready", cmd_ready, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      count_clear("clear_cycles_midrst");
      hold_ack = 1'b0;
      check_cnt(0, 0, 0, 0);
      exp_txn(1'b0, 32'h5000);
      send(4'd0, 32'h5000, K_MISS);
      wait_idle();
      check_cnt(1, 0, 0, 1);

      repeat (5) @(negedge clk);
      check("pulse_q_empty", pulse_q.size(), 0);
      check("txn_q_empty", txn_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
